// File: rtl/vertex_fifo_reader_pkg.sv
// vertex_pkg: shared constants and state type for the vertex FIFO drain path.
//   VTX_DBITS   : width of one vertex FIFO entry
//   VTX_WBITS   : width of one downstream beat
//   VFR_CNTW    : width of the optional transmitted-entry counter
//   vfr_state_t : reader FSM state (IDLE = nothing held, BUSY = entry held and streaming)
package vertex_pkg;

  localparam int VTX_DBITS = 96;
  localparam int VTX_WBITS = 32;
  localparam int VFR_CNTW  = 16;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } vfr_state_t;

endpackage

// File: rtl/vertex_fifo_reader.sv
// vertex_fifo_reader: drains a show-ahead vertex FIFO and serialises each entry into
// DBITS/WBITS beats on a valid/ready stream, least-significant word first.
//
// Optional feature macro: VFR_COUNT_EN (adds the ent_count output and its counter).
//
// Ports
//   clk         in   1      clock, all state updates on posedge
//   reset       in   1      asynchronous active-low reset
//   fifo_empty  in   1      FIFO empty flag
//   fifo_dout   in   DBITS  FIFO head entry, valid whenever fifo_empty==0
//   fifo_rd     out  1      pop strobe, combinational, one cycle per entry
//   flush       in   1      synchronous drop of the held entry
//   out_valid   out  1      beat valid
//   out_ready   in   1      downstream accepts beat
//   out_data    out  WBITS  current beat
//   out_first   out  1      beat is word 0 of its entry
//   out_last    out  1      beat is the final word of its entry
//   dbg_state_o out  1      current FSM state, for observation only
//   ent_count   out  16     entries fully transmitted (VFR_COUNT_EN builds only)
//
// Handshake: a beat transfers on a clock edge where out_valid && out_ready. out_valid is
// never withdrawn and out_data/out_first/out_last never change while a beat waits for
// out_ready, except when flush or reset discards the held entry.
module vertex_fifo_reader
  import vertex_pkg::*;
#(
  parameter int DBITS = VTX_DBITS,
  parameter int WBITS = VTX_WBITS
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             fifo_empty,
  input  logic [DBITS-1:0] fifo_dout,
  output logic             fifo_rd,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WBITS-1:0] out_data,
  output logic             out_first,
  output logic             out_last,
  output vfr_state_t       dbg_state_o
`ifdef VFR_COUNT_EN
  ,
  output logic [VFR_CNTW-1:0] ent_count
`endif
);

  localparam int WORDS = DBITS / WBITS;
  localparam int IDXW  = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(WORDS - 1);
  localparam logic [IDXW-1:0] IDX_ONE  = IDXW'(1);

  vfr_state_t                  state_q, state_d;
  logic [IDXW-1:0]             idx_q,   idx_d;
  logic [WORDS-1:0][WBITS-1:0] hold_q,  hold_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      hold_q  <= hold_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    hold_d    = hold_q;
    fifo_rd   = 1'b0;
    out_valid = (state_q == BUSY);

    if (flush) begin
      // Flush outranks everything: no pop, held entry abandoned, FIFO left intact.
      state_d = IDLE;
      idx_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          // The reset gate keeps the strobe quiet while the FIFO may already hold data.
          if (!fifo_empty && reset) begin
            fifo_rd = 1'b1;
            hold_d  = fifo_dout;
            idx_d   = '0;
            state_d = BUSY;
          end
        end
        BUSY: begin
          if (out_ready) begin
            if (idx_q == LAST_IDX) begin
              idx_d = '0;
              if (!fifo_empty) begin
                // Reload on the last accepted beat so entries stream without a bubble.
                fifo_rd = 1'b1;
                hold_d  = fifo_dout;
              end else begin
                state_d = IDLE;
              end
            end else begin
              idx_d = idx_q + IDX_ONE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign out_data    = hold_q[idx_q];
  assign out_first   = out_valid && (idx_q == '0);
  assign out_last    = out_valid && (idx_q == LAST_IDX);
  assign dbg_state_o = state_q;

`ifdef VFR_COUNT_EN
  logic [VFR_CNTW-1:0] cnt_q, cnt_d;
  logic                cnt_inc;

  // An entry counts only when its final beat is actually accepted; a flushed entry never does.
  assign cnt_inc = (state_q == BUSY) && out_ready && !flush && (idx_q == LAST_IDX);

  always_comb begin
    cnt_d = cnt_q;
    if (cnt_inc) cnt_d = cnt_q + VFR_CNTW'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign ent_count = cnt_q;
`endif

endmodule
